// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, bank state type and bin-order helper for the 8-point FFT pipeline
//
// Purpose: common definitions for fft_stage_* and fft_out_serializer.
//   FFT_N        default log2 of the data word width (word is 2**FFT_N bits)
//   WORD_W       default data word width
//   FFT_POINTS   points per frame
//   FFT_LOG2     bits of a bin index
//   bank_state_t per-bank occupancy of the output ping-pong buffer
//   bitrev3()    3-bit bit reversal (final-stage output k carries bin bitrev3(k))
package fft_pkg;

  localparam int FFT_N      = 4;
  localparam int WORD_W     = 2 ** FFT_N;
  localparam int FFT_POINTS = 8;
  localparam int FFT_LOG2   = 3;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

  function automatic logic [FFT_LOG2-1:0] bitrev3(input logic [FFT_LOG2-1:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// rtl/fft_frame_buf.sv - one bank of 8 complex words, write-all port and indexed read port
//
// Purpose: storage for one captured FFT frame.
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-low reset (clears all words)
//   wr_en          in   write all 8 complex words this cycle
//   wr_r, wr_i     in   8 packed words, word k at [k*W +: W]
//   rd_idx         in   read slot 0..7
//   rd_r, rd_i     out  word at rd_idx, read combinationally from the registers
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [FFT_POINTS*W-1:0]    wr_r,
  input  logic [FFT_POINTS*W-1:0]    wr_i,
  input  logic [FFT_LOG2-1:0]        rd_idx,
  output logic [W-1:0]               rd_r,
  output logic [W-1:0]               rd_i
);

  logic [W-1:0] mem_r [FFT_POINTS];
  logic [W-1:0] mem_i [FFT_POINTS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < FFT_POINTS; k++) begin
        mem_r[k] <= '0;
        mem_i[k] <= '0;
      end
    end else if (wr_en) begin
      for (int k = 0; k < FFT_POINTS; k++) begin
        mem_r[k] <= wr_r[k*W +: W];
        mem_i[k] <= wr_i[k*W +: W];
      end
    end
  end

  assign rd_r = mem_r[rd_idx];
  assign rd_i = mem_i[rd_idx];

endmodule

// File: rtl/fft_out_serializer.sv
// rtl/fft_out_serializer.sv - ping-pong capture of FFT final-stage frames, streamed out in natural bin order
//
// Purpose: captures one 8-point complex frame per input handshake into one of two banks,
//   then streams X[0]..X[7] one bin per beat, undoing the bit-reversed order of the final stage.
// Optional feature: FFT_OUT_SCALE_EN, when defined, scales every output word by 1/8 with
//   round-half-up ((x + 4) >>> 3); otherwise output words are the captured words, bit-exact.
// Ports:
//   clk                  in   rising-edge clock
//   rst                  in   asynchronous active-low reset
//   in_valid / in_ready  in/out  frame handshake; in_ready depends on registers and rst only
//   in_0_r..in_7_r       in   real parts of final-stage outputs 0..7 (bit-reversed bin order)
//   in_0_i..in_7_i       in   imaginary parts of final-stage outputs 0..7
//   out_valid/out_ready  out/in  beat handshake
//   out_r, out_i         out  bin value X[out_idx]
//   out_idx              out  natural-order bin index
//   out_last             out  high on the beat with out_idx == 7
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int N = FFT_N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2**N-1:0]     in_0_r,
  input  logic [2**N-1:0]     in_1_r,
  input  logic [2**N-1:0]     in_2_r,
  input  logic [2**N-1:0]     in_3_r,
  input  logic [2**N-1:0]     in_4_r,
  input  logic [2**N-1:0]     in_5_r,
  input  logic [2**N-1:0]     in_6_r,
  input  logic [2**N-1:0]     in_7_r,
  input  logic [2**N-1:0]     in_0_i,
  input  logic [2**N-1:0]     in_1_i,
  input  logic [2**N-1:0]     in_2_i,
  input  logic [2**N-1:0]     in_3_i,
  input  logic [2**N-1:0]     in_4_i,
  input  logic [2**N-1:0]     in_5_i,
  input  logic [2**N-1:0]     in_6_i,
  input  logic [2**N-1:0]     in_7_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2**N-1:0]     out_r,
  output logic [2**N-1:0]     out_i,
  output logic [2:0]          out_idx,
  output logic                out_last
);

  localparam int W = 2 ** N;

  bank_state_t          bank_st   [2];
  bank_state_t          bank_st_n [2];
  logic                 wbank, wbank_n;
  logic                 rbank, rbank_n;
  logic [FFT_LOG2-1:0]  cnt, cnt_n;

  logic                 cap;
  logic                 beat;
  logic                 rel;

  logic [FFT_POINTS*W-1:0] wr_r;
  logic [FFT_POINTS*W-1:0] wr_i;
  logic [FFT_LOG2-1:0]     rd_idx;
  logic [W-1:0]            rd_r0, rd_i0, rd_r1, rd_i1;
  logic [W-1:0]            raw_r, raw_i;

  function automatic logic [W-1:0] out_word(input logic [W-1:0] x);
`ifdef FFT_OUT_SCALE_EN
    // One guard bit keeps x + 4 from wrapping near the positive limit.
    logic signed [W:0] t;
    t = $signed({x[W-1], x}) + $signed((W+1)'(4));
    t = t >>> 3;
    return t[W-1:0];
`else
    return x;
`endif
  endfunction

  // Status outputs come only from registered state; rst gates in_ready so a
  // frame offered during reset is never taken.
  assign in_ready  = rst & (bank_st[wbank] == BANK_EMPTY);
  assign out_valid = (bank_st[rbank] == BANK_FULL);

  assign cap  = in_valid & in_ready;
  assign beat = out_valid & out_ready;
  assign rel  = beat & (cnt == 3'd7);

  // Capture and release can coincide only on different banks (capture needs
  // an empty bank, release a full one), so both updates apply independently.
  always_comb begin
    bank_st_n[0] = bank_st[0];
    bank_st_n[1] = bank_st[1];
    wbank_n      = wbank;
    rbank_n      = rbank;
    cnt_n        = cnt;
    if (cap) begin
      bank_st_n[wbank] = BANK_FULL;
      wbank_n          = ~wbank;
    end
    if (rel) begin
      bank_st_n[rbank] = BANK_EMPTY;
      rbank_n          = ~rbank;
    end
    if (beat) begin
      cnt_n = cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      cnt        <= '0;
    end else begin
      bank_st[0] <= bank_st_n[0];
      bank_st[1] <= bank_st_n[1];
      wbank      <= wbank_n;
      rbank      <= rbank_n;
      cnt        <= cnt_n;
    end
  end

  assign wr_r = {in_7_r, in_6_r, in_5_r, in_4_r, in_3_r, in_2_r, in_1_r, in_0_r};
  assign wr_i = {in_7_i, in_6_i, in_5_i, in_4_i, in_3_i, in_2_i, in_1_i, in_0_i};

  // Natural bin cnt lives in slot bitrev3(cnt) of the captured frame.
  assign rd_idx = bitrev3(cnt);

  fft_frame_buf #(.W(W)) u_bank0 (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (cap & ~wbank),
    .wr_r   (wr_r),
    .wr_i   (wr_i),
    .rd_idx (rd_idx),
    .rd_r   (rd_r0),
    .rd_i   (rd_i0)
  );

  fft_frame_buf #(.W(W)) u_bank1 (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (cap & wbank),
    .wr_r   (wr_r),
    .wr_i   (wr_i),
    .rd_idx (rd_idx),
    .rd_r   (rd_r1),
    .rd_i   (rd_i1)
  );

  assign raw_r = rbank ? rd_r1 : rd_r0;
  assign raw_i = rbank ? rd_i1 : rd_i0;

  assign out_r    = out_word(raw_r);
  assign out_i    = out_word(raw_i);
  assign out_idx  = cnt;
  assign out_last = (cnt == 3'd7);

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb/tb_fft_out_serializer.sv - directed self-checking bench for fft_out_serializer
module tb_fft_out_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_r [8];
  logic [15:0] in_i [8];
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_r;
  logic [15:0] out_i;
  logic [2:0]  out_idx;
  logic        out_last;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fft_out_serializer #(.N(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_0_r(in_r[0]), .in_1_r(in_r[1]), .in_2_r(in_r[2]), .in_3_r(in_r[3]),
    .in_4_r(in_r[4]), .in_5_r(in_r[5]), .in_6_r(in_r[6]), .in_7_r(in_r[7]),
    .in_0_i(in_i[0]), .in_1_i(in_i[1]), .in_2_i(in_i[2]), .in_3_i(in_i[3]),
    .in_4_i(in_i[4]), .in_5_i(in_i[5]), .in_6_i(in_i[6]), .in_7_i(in_i[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_i(out_i), .out_idx(out_idx), .out_last(out_last)
  );

  function automatic int br(input int k);
    logic [2:0] v;
    v = 3'(k);
    return int'({v[0], v[1], v[2]});
  endfunction

  function automatic logic [15:0] sc(input logic [15:0] x);
`ifdef FFT_OUT_SCALE_EN
    logic signed [16:0] t;
    t = $signed({x[15], x}) + 17'sd4;
    t = t >>> 3;
    return t[15:0];
`else
    return x;
`endif
  endfunction

  // Frame f: input k real = 16*k + f, imag = 256*f - k.
  function automatic logic [15:0] exp_r(input int f, input int b);
    return sc(16'(16 * br(b) + f));
  endfunction

  function automatic logic [15:0] exp_i(input int f, input int b);
    return sc(16'(256 * f - br(b)));
  endfunction

  task automatic load_frame(input int f);
    for (int k = 0; k < 8; k++) begin
      in_r[k] = 16'(16 * k + f);
      in_i[k] = 16'(256 * f - k);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; load_frame(0);
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b want=0", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", out_valid); else passes++;
    checks++;
    if ({out_idx, out_last, out_r, out_i} !== {3'd0, 1'b0, 16'd0, 16'd0})
      $display("FAIL rst_outputs got idx=%0d last=%b r=%h i=%h want all 0", out_idx, out_last, out_r, out_i);
    else passes++;
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_frame_dropped out_valid got=%b want=0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_in_ready got=%b want=1", in_ready); else passes++;
  endtask

  task automatic test_single_frame;
    int tab [8] = '{0, 64, 32, 96, 16, 80, 48, 112};
    int b;
    load_frame(0); in_valid = 1'b1; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b1) $display("FAIL single_in_ready got=%b want=1", in_ready); else passes++;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) $display("FAIL single_latency out_valid got=%b want=1", out_valid); else passes++;
    b = 0;
    for (int c = 0; c < 20 && b < 8; c++) begin
      if (out_valid) begin
        checks++;
        if ({out_idx, out_r, out_i, out_last} !== {3'(b), sc(16'(tab[b])), sc(16'(-br(b))), (b == 7)})
          $display("FAIL single_beat%0d got idx=%0d r=%0d i=%h last=%b want idx=%0d r=%0d i=%h last=%b",
                   b, out_idx, out_r, out_i, out_last, b, sc(16'(tab[b])), sc(16'(-br(b))), (b == 7));
        else passes++;
        b++;
      end
      @(negedge clk);
    end
    checks++; if (b !== 8) $display("FAIL single_beat_count got=%0d want=8", b); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL single_drained out_valid got=%b want=0", out_valid); else passes++;
  endtask

  task automatic test_backpressure;
    int b;
    load_frame(1); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    b = 0;
    for (int c = 0; c < 40 && b < 8; c++) begin
      out_ready = (c % 2 == 0);
      if (out_valid) begin
        // On stall cycles the model beat does not advance, so this also checks hold.
        checks++;
        if ({out_idx, out_r, out_i, out_last} !== {3'(b), exp_r(1, b), exp_i(1, b), (b == 7)})
          $display("FAIL bp_beat%0d ready=%b got idx=%0d r=%h i=%h last=%b want idx=%0d r=%h i=%h",
                   b, out_ready, out_idx, out_r, out_i, out_last, b, exp_r(1, b), exp_i(1, b));
        else passes++;
        if (out_ready) b++;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++; if (b !== 8) $display("FAIL bp_beat_count got=%0d want=8", b); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_drained out_valid got=%b want=0", out_valid); else passes++;
  endtask

  // Offers three frames as fast as accepted; out_ready rises at cycle ready_c.
  task automatic run_three(input string nm, input int f0, input int ready_c, input int want_c2,
                           output int valid_cycles, output int first_c, output int last_c, output int bad_ready);
    int fr [3];
    int cap_c [3];
    int nf, nb, f, b;
    fr = '{f0, f0 + 1, f0 + 2};
    cap_c = '{-1, -1, -1};
    nf = 0; nb = 0; valid_cycles = 0; first_c = -1; last_c = -1; bad_ready = 0;
    for (int c = 0; c < 60; c++) begin
      in_valid  = (nf < 3);
      if (nf < 3) load_frame(fr[nf]);
      out_ready = (c >= ready_c);
      if (c >= 2 && c < want_c2 && in_ready !== 1'b0) bad_ready++;
      if (in_valid && in_ready) begin
        cap_c[nf] = c;
        nf++;
      end
      if (out_valid) begin
        valid_cycles++;
        if (first_c < 0) first_c = c;
        last_c = c;
        if (out_ready && nb < 24) begin
          f = fr[nb / 8]; b = nb % 8;
          checks++;
          if ({out_idx, out_r, out_i, out_last} !== {3'(b), exp_r(f, b), exp_i(f, b), (b == 7)})
            $display("FAIL %s_beat%0d got idx=%0d r=%h i=%h last=%b want idx=%0d r=%h i=%h",
                     nm, nb, out_idx, out_r, out_i, out_last, b, exp_r(f, b), exp_i(f, b));
          else passes++;
          nb++;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (cap_c[0] !== 0 || cap_c[1] !== 1 || cap_c[2] !== want_c2)
      $display("FAIL %s_capture_cycles got=%0d,%0d,%0d want=0,1,%0d", nm, cap_c[0], cap_c[1], cap_c[2], want_c2);
    else passes++;
    checks++; if (nb !== 24) $display("FAIL %s_beat_count got=%0d want=24", nm, nb); else passes++;
  endtask

  task automatic test_back_to_back;
    int vc, fc, lc, bad;
    run_three("b2b", 2, 0, 9, vc, fc, lc, bad);
    checks++;
    if (vc !== 24 || fc !== 1 || lc !== 24)
      $display("FAIL b2b_contiguous got cycles=%0d first=%0d last=%0d want 24,1,24", vc, fc, lc);
    else passes++;
  endtask

  task automatic test_full_stall;
    int vc, fc, lc, bad;
    run_three("stall", 5, 5, 13, vc, fc, lc, bad);
    checks++; if (bad !== 0) $display("FAIL stall_in_ready_low got %0d high cycles want 0", bad); else passes++;
  endtask

  task automatic test_reset_mid_frame;
    int b;
    load_frame(8); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd4)
      $display("FAIL rmid_at_beat4 got valid=%b idx=%0d want 1,4", out_valid, out_idx);
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL rmid_in_reset got valid=%b in_ready=%b want 0,0", out_valid, in_ready);
    else passes++;
    load_frame(9); in_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_idx !== 3'd0)
      $display("FAIL rmid_held got valid=%b in_ready=%b idx=%0d want 0,0,0", out_valid, in_ready, out_idx);
    else passes++;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL rmid_dropped out_valid got=%b want=0", out_valid); else passes++;
    load_frame(10); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    b = 0;
    for (int c = 0; c < 20 && b < 8; c++) begin
      if (out_valid) begin
        checks++;
        if ({out_idx, out_r, out_i, out_last} !== {3'(b), exp_r(10, b), exp_i(10, b), (b == 7)})
          $display("FAIL rmid_beat%0d got idx=%0d r=%h i=%h want idx=%0d r=%h i=%h",
                   b, out_idx, out_r, out_i, b, exp_r(10, b), exp_i(10, b));
        else passes++;
        b++;
      end
      @(negedge clk);
    end
    checks++; if (b !== 8) $display("FAIL rmid_beat_count got=%0d want=8", b); else passes++;
  endtask

`ifdef FFT_OUT_SCALE_EN
  task automatic test_scale;
    for (int k = 0; k < 8; k++) begin
      in_r[k] = 16'd0;
      in_i[k] = 16'd0;
    end
    in_r[0] = 16'h7FFF; in_i[0] = 16'hFFF4; in_r[4] = 16'd12;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_r !== 16'd4096 || out_i !== 16'hFFFF)
      $display("FAIL scale_x0 got r=%0d i=%h want r=4096 i=ffff", out_r, out_i);
    else passes++;
    @(negedge clk);
    checks++;
    if (out_idx !== 3'd1 || out_r !== 16'd2)
      $display("FAIL scale_x1 got idx=%0d r=%0d want idx=1 r=2", out_idx, out_r);
    else passes++;
    repeat (8) @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_r[k] = 16'd0;
      in_i[k] = 16'd0;
    end
    test_reset;
    test_single_frame;
    test_backpressure;
    test_back_to_back;
    test_full_stall;
    test_reset_mid_frame;
`ifdef FFT_OUT_SCALE_EN
    test_scale;
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
